bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter. It is the inverse of the binary-to-decimal-digit path that drives the HEX displays. It takes DIGITS packed BCD digits from switch entry and produces an unsigned binary operand for the add/subtract datapath. Multiply-accumulate runs one digit per cycle, with valid/ready handshakes on both sides.

Parameters:
DIGITS  3   number of BCD digits in bcd_in; MSD in the top nibble
BIN_W   10  width of bin_out; results >= 2**BIN_W saturate

Ports:
clk        input   1          single clock, rising edge
rst_n      input   1          reset, asynchronous, active-low
in_valid   input   1          bcd_in holds a digit set to convert
in_ready   output  1          converter can accept; high only in IDLE
bcd_in     input   4*DIGITS   packed BCD; nibble i = 10**i digit
out_valid  output  1          result valid; held until accepted
out_ready  input   1          consumer accepts result
bin_out    output  BIN_W      binary result
err_digit  output  1          some input nibble > 9
ovf        output  1          value >= 2**BIN_W; bin_out saturated

Behaviour:
Interface: one clock (clk); reset rst_n is asynchronous and active-low.

Reset values:
- out_valid=0, bin_out=0, err_digit=0, ovf=0; state=IDLE.
- in_ready is decoded from state, so it is 1 during and after reset.

States:
- IDLE: in_ready=1. On an edge with in_valid & in_ready:
  - capture bcd_in;
  - flag = OR over nibbles of (nibble > 9);
  - acc = 0; idx = DIGITS-1; go to CONV.
- CONV: each edge does acc <= acc*10 + nibble[idx], computed as (acc<<3)+(acc<<1)+digit.
  - acc width is 4*DIGITS bits, enough because 10**DIGITS < 16**DIGITS.
  - If idx==0, go to DONE; otherwise idx <= idx-1.
  - CONV lasts exactly DIGITS cycles.
- DONE: out_valid=1; bin_out, err_digit and ovf are registered on DONE entry and held stable.
  - On an edge with out_valid & out_ready, go to IDLE and drop out_valid.

Latency:
- Accept edge E0; out_valid rises after edge E0+DIGITS.
- Minimum spacing between accepts is DIGITS+2 cycles, given out_ready=1.

Result rules, applied on DONE entry:
- If flag=1: err_digit=1, ovf=0, bin_out=0. Invalid nibbles are still accumulated, but the result is discarded.
- Else if acc >= 2**BIN_W: ovf=1, bin_out = all ones.
- Else: bin_out = acc[BIN_W-1:0], ovf=0, err_digit=0.

Boundary rules:
- in_valid is ignored outside IDLE (in_ready=0). No input buffering.
- out_ready low holds DONE indefinitely; outputs do not change.
- out_ready high before DONE has no effect.
- Handshake leaving DONE: in_ready rises the next cycle, so there is no same-cycle accept.
- rst_n low in any state aborts immediately: IDLE, all outputs at reset values, partial acc discarded.

Decomposition:
- Shared constants header: state encodings (IDLE/CONV/DONE), BCD_MAX=9, width helper ACC_W = 4*DIGITS.
- One combinational sub-module, bcd_mac10:
  - inputs acc[ACC_W-1:0] and digit[3:0];
  - output acc*10+digit, truncated to ACC_W.
- FSM, index counter and result registers stay in bcd_to_bin_seq.

Test Plan:
1. bcd_in=12'h123, in_valid 1 cycle, out_ready=1 -> out_valid exactly 3 cycles after accept; bin_out=123, err_digit=0, ovf=0; in_ready back to 1 the cycle after handshake.
2. Boundary values: 12'h000 -> bin_out=0; 12'h999 -> bin_out=999, ovf=0; 12'h001 -> bin_out=1.
3. bcd_in=12'h1A5 -> err_digit=1, bin_out=0, ovf=0. Then 12'h045 -> err_digit=0, bin_out=45 (flag cleared per conversion).
4. BIN_W=7 instance (matches 7-bit arithmetic path): 12'h127 -> bin_out=127, ovf=0; 12'h128 -> bin_out=127, ovf=1; 12'h999 -> bin_out=127, ovf=1.
5. Backpressure, with a new bcd_in on in_valid throughout:
   - 12'h042, then out_ready=0 for 5 cycles -> out_valid stays 1, bin_out=42 stable, in_ready=0, new bcd_in not captured;
   - out_ready=1 -> handshake, next accepted value converts correctly.
6. Mid-operation reset: assert rst_n=0 asynchronously during the second CONV cycle of 12'h777.
   - Required: out_valid=0, bin_out=0, in_ready=1 immediately.
   - After release, 12'h250 -> bin_out=250 with latency 3.

Source files
------------

// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared constants for the sequential BCD-to-binary converter:
// FSM state encodings, the largest legal BCD digit and the accumulator width helper.
package bcd_to_bin_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // 4 bits per digit always holds 10**DIGITS - 1, since 10**DIGITS < 16**DIGITS.
  function automatic int acc_w(input int digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_mac10.sv
// Combinational multiply-by-ten-and-add step used once per BCD digit.
// The result wraps to ACC_W bits; the caller sizes ACC_W so no real value is lost.
module bcd_mac10 #(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [3:0]       i_digit,
  output logic [ACC_W-1:0] o_acc
);

  // acc*10 as two shifts and an add, keeping it multiplier-free.
  assign o_acc = (i_acc << 3) + (i_acc << 1) + ACC_W'(i_digit);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per cycle, MSD first,
// with valid/ready handshakes on input and output, digit error and saturation flags.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err_digit,
  output logic                  ovf
);

  localparam int ACC_W = acc_w(DIGITS);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_bcd;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_mac;
  logic [IDX_W-1:0]   r_idx;
  logic               r_flag;
  logic [3:0]         w_nibble [DIGITS];
  logic [DIGITS-1:0]  w_nib_bad;
  logic [3:0]         w_digit;
  logic               w_accept;
  logic               w_release;
  logic               w_last;
  logic               w_ovf;
  logic [BIN_W-1:0]   w_trunc;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign w_nibble[gi]  = r_bcd[4*gi +: 4];
      assign w_nib_bad[gi] = (bcd_in[4*gi +: 4] > BCD_MAX);
    end
  endgenerate

  assign w_digit = w_nibble[r_idx];

  bcd_mac10 #(
    .ACC_W (ACC_W)
  ) u_mac (
    .i_acc   (r_acc),
    .i_digit (w_digit),
    .o_acc   (w_mac)
  );

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_release = out_valid & out_ready;
  assign w_last    = (r_idx == '0);

  // Saturation check only exists when the accumulator can exceed the output width.
  generate
    if (ACC_W > BIN_W) begin : g_sat
      assign w_ovf   = |w_mac[ACC_W-1:BIN_W];
      assign w_trunc = w_mac[BIN_W-1:0];
    end else begin : g_nosat
      assign w_ovf   = 1'b0;
      assign w_trunc = BIN_W'(w_mac);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept)  w_state_next = ST_CONV;
      ST_CONV: if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (w_release) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd     <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_flag    <= 1'b0;
      bin_out   <= '0;
      err_digit <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bcd  <= bcd_in;
        r_flag <= |w_nib_bad;
        r_acc  <= '0;
        r_idx  <= IDX_LAST;
      end
      if (r_state == ST_CONV) begin
        r_acc <= w_mac;
        if (!w_last) begin
          r_idx <= r_idx - 1'b1;
        end else if (r_flag) begin
          // Bad digits were accumulated anyway; the value is meaningless, so report zero.
          err_digit <= 1'b1;
          ovf       <= 1'b0;
          bin_out   <= '0;
        end else if (w_ovf) begin
          err_digit <= 1'b0;
          ovf       <= 1'b1;
          bin_out   <= '1;
        end else begin
          err_digit <= 1'b0;
          ovf       <= 1'b0;
          bin_out   <= w_trunc;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized and directed bench for bcd_to_bin_seq; a 10-bit and a 7-bit
// instance share stimulus and are checked against a decimal arithmetic model.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] bcd_in;

  logic        ir10, ov10, err10, ovf10;
  logic [9:0]  bin10;
  logic        ir7, ov7, err7, ovf7;
  logic [6:0]  bin7;

  int n_cmp;
  int n_err;

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (ir10),
    .bcd_in    (bcd_in),
    .out_valid (ov10),
    .out_ready (out_ready),
    .bin_out   (bin10),
    .err_digit (err10),
    .ovf       (ovf10)
  );

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(7)) dut7 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (ir7),
    .bcd_in    (bcd_in),
    .out_valid (ov7),
    .out_ready (out_ready),
    .bin_out   (bin7),
    .err_digit (err7),
    .ovf       (ovf7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input logic [11:0] b);
    bit e;
    e = 1'b0;
    for (int i = 0; i < 3; i++) if (b[4*i +: 4] > 4'd9) e = 1'b1;
    return e;
  endfunction

  function automatic int ref_val(input logic [11:0] b);
    int v;
    int p;
    v = 0;
    p = 1;
    for (int i = 0; i < 3; i++) begin
      v = v + p * int'(b[4*i +: 4]);
      p = p * 10;
    end
    return v;
  endfunction

  function automatic int ref_bin(input logic [11:0] b, input int w);
    int lim;
    lim = 1 << w;
    if (ref_err(b)) return 0;
    if (ref_val(b) >= lim) return lim - 1;
    return ref_val(b);
  endfunction

  function automatic int ref_ovf(input logic [11:0] b, input int w);
    return (!ref_err(b) && ref_val(b) >= (1 << w)) ? 1 : 0;
  endfunction

  task automatic check_result(input string tag, input logic [11:0] b);
    check_eq({tag, "_valid10"}, ov10,  1);
    check_eq({tag, "_valid7"},  ov7,   1);
    check_eq({tag, "_bin10"},   bin10, ref_bin(b, 10));
    check_eq({tag, "_err10"},   err10, ref_err(b));
    check_eq({tag, "_ovf10"},   ovf10, ref_ovf(b, 10));
    check_eq({tag, "_bin7"},    bin7,  ref_bin(b, 7));
    check_eq({tag, "_err7"},    err7,  ref_err(b));
    check_eq({tag, "_ovf7"},    ovf7,  ref_ovf(b, 7));
    check_eq({tag, "_rdy_done"}, ir10, 0);
  endtask

  // One conversion: accept b, optionally stall the consumer while offering an intruder value.
  task automatic run_one(input logic [11:0] b, input int stall, input logic [11:0] intruder);
    int n;
    n = 0;
    while (!ir10 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ready_before", ir10, 1);
    in_valid = 1'b1;
    bcd_in   = b;
    @(posedge clk); #1;
    if (stall > 0) out_ready = 1'b0;
    in_valid = (stall > 0);
    bcd_in   = intruder;
    check_eq("busy_after_accept", ir10, 0);
    n = 0;
    while (!ov10 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", n, 3);
    check_result("res", b);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check_result("hold", b);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("valid_drop", ov10, 0);
    check_eq("ready_back", ir10, 1);
    $display("txn bcd=%03h stall=%0d lat=%0d bin10=%0d err=%0d ovf=%0d bin7=%0d ovf7=%0d",
             b, stall, n, bin10, err10, ovf10, bin7, ovf7);
  endtask

  logic [11:0] directed [9];
  logic [11:0] rb;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    bcd_in    = '0;
    #3;
    check_eq("rst_ready",  ir10,  1);
    check_eq("rst_valid",  ov10,  0);
    check_eq("rst_bin",    bin10, 0);
    check_eq("rst_err",    err10, 0);
    check_eq("rst_ovf",    ovf10, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    directed = '{12'h123, 12'h000, 12'h999, 12'h001, 12'h1A5,
                 12'h045, 12'h127, 12'h128, 12'h999};
    foreach (directed[i]) run_one(directed[i], 0, 12'h000);

    run_one(12'h042, 5, 12'h876);
    run_one(12'h031, 0, 12'h000);
    run_one(12'h999, 0, 12'h000);

    // Asynchronous reset during the second CONV cycle of 777.
    in_valid = 1'b1;
    bcd_in   = 12'h777;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", ov10,  0);
    check_eq("arst_bin",   bin10, 0);
    check_eq("arst_bin7",  bin7,  0);
    check_eq("arst_ready", ir10,  1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_one(12'h250, 0, 12'h000);

    for (int t = 0; t < 40; t++) begin
      for (int d = 0; d < 3; d++) rb[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
      run_one(rb, $urandom_range(0, 3), 12'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
